// File: rtl/async_fifo_wr_arb.sv
`default_nettype none
// ============================================================================
// Module      : async_fifo_wr_arb
// Description : Round-robin burst arbiter feeding the write side of a FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module async_fifo_wr_arb #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                        wclk,
    input  logic                        wrst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        wfull,
    output logic                        winc,
    output logic [DATA_W-1:0]           wdata,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        busy,
    output logic [15:0]                 stall_cnt
);

    localparam int c_gid_w = $clog2(NUM_REQ);
    localparam int c_cnt_w = $clog2(MAX_BURST + 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_gid_w-1:0]   r_grant_id;
    logic [c_gid_w-1:0]   w_grant_nxt;
    logic [c_gid_w-1:0]   r_rr_ptr;
    logic [c_gid_w-1:0]   w_rr_nxt;
    logic [c_gid_w-1:0]   w_pick;
    logic [c_gid_w-1:0]   w_cand;
    logic [c_gid_w-1:0]   w_next_ptr;
    logic [c_cnt_w-1:0]   r_beat_cnt;
    logic [c_cnt_w-1:0]   w_beat_nxt;
    logic [15:0]          r_stall_cnt;
    logic [DATA_W-1:0]    w_slice;
    logic                 w_found;
    logic                 w_busy;
    logic                 w_own_valid;
    logic                 w_own_last;
    logic                 w_xfer;
    logic                 w_last_beat;
    int                   w_idx;

    assign w_busy      = (r_state == S_BURST);
    assign w_own_valid = req_valid[r_grant_id];
    assign w_own_last  = req_last[r_grant_id];
    assign w_xfer      = w_busy & w_own_valid & ~wfull;
    assign w_last_beat = (r_beat_cnt == c_cnt_w'(MAX_BURST - 1));
    assign w_next_ptr  = (r_grant_id == c_gid_w'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;

    // Owner data mux over constant slices keeps a non-power-of-two NUM_REQ safe.
    always_comb begin
        w_slice = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant_id == c_gid_w'(i)) begin
                w_slice = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Scan from farthest to nearest so the last hit is the first valid after rr_ptr.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = 0;
        w_cand  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            w_cand = c_gid_w'(w_idx);
            if (req_valid[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant_id;
        w_rr_nxt    = r_rr_ptr;
        w_beat_nxt  = r_beat_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_grant_nxt = w_pick;
                    w_beat_nxt  = '0;
                    w_state_nxt = S_BURST;
                end
            end
            S_BURST: begin
                if (w_xfer) begin
                    w_beat_nxt = r_beat_cnt + 1'b1;
                end
                if (!w_own_valid || (w_xfer && (w_own_last || w_last_beat))) begin
                    w_state_nxt = S_IDLE;
                    w_rr_nxt    = w_next_ptr;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            r_state    <= S_IDLE;
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant_id <= w_grant_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_beat_cnt <= w_beat_nxt;
        end
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            r_stall_cnt <= '0;
        end else if (w_busy && w_own_valid && wfull && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    always_comb begin
        req_ready = '0;
        if (w_busy && !wfull) begin
            req_ready[r_grant_id] = 1'b1;
        end
    end

    assign winc      = w_xfer;
    assign wdata     = w_busy ? w_slice : '0;
    assign grant_id  = r_grant_id;
    assign busy      = w_busy;
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire
